tdc_corr_histogram: RTL
=======================

# tdc_corr_histogram

Start-stop correlation histogrammer that sits directly downstream of the TDC. It takes each new TDC event (start channel, end channel, interval) and increments the matching bin in one of two histograms: pulse1→pulse2 or pulse2→pulse1. Simultaneous hits go to a separate coincidence counter. On request, it freezes and streams all bins out over a valid/ready port, clearing each bin as it is read, so the single-pixel-imaging controller can read one correlation frame per pattern.

## Interface
Parameters:
- COUNT_W, 16, width of each bin counter; counters saturate.
- DROP_W, 16, width of the dropped-event counter; saturates.

Ports:
- clk  in  1  system clock (500 MHz domain, same as TDC).
- rst_n  in  1  reset, asynchronous, active-low.
- data_arrived  in  1  TDC event strobe; held high ≥2 cycles per event.
- START_signal  in  2  TDC start channel code.
- END_signal  in  2  TDC end channel code.
- INTERVAL  in  6  TDC interval in clk cycles.
- acq_en  in  1  accumulation enable.
- dump_req  in  1  single-cycle request to start readout.
- out_valid  out  1  readout word valid.
- out_ready  in  1  consumer ready.
- out_idx  out  8  word index, 0..128.
- out_data  out  COUNT_W  bin count.
- out_last  out  1  high on word 128.
- busy  out  1  high in DRAIN.
- dropped  out  DROP_W  events lost while in DRAIN; cleared only by reset.

Reset value of every output: 0.

## Operation
- Channel codes: CH1=2'b10 (pulse1 only), CH2=2'b01 (pulse2 only), BOTH=2'b11, NONE=2'b00.
- Event detection: an event occurs in a cycle with `data_arrived & ~data_arrived_q`. All three TDC fields are sampled in that same cycle.
- Event classification, applied only in ACQ with acq_en=1:
  - START=CH1, END=CH2 → fwd[INTERVAL]++.
  - START=CH2, END=CH1 → rev[INTERVAL]++.
  - START=NONE, END=BOTH → coinc++.
  - Any other code (same-channel, START=BOTH, or first event after TDC reset) → ignored.
- With acq_en=0 in ACQ, events are ignored. They are not counted as dropped.
- Any event in DRAIN → dropped++. The histograms are untouched.
- All counters saturate at their all-ones value.
- FSM:
  - ACQ: dump_req → DRAIN with word index = 0.
  - DRAIN: presents word[idx].
    - idx 0..63 = fwd[idx].
    - idx 64..127 = rev[idx-64].
    - idx 128 = coinc, with out_last=1.
  - On out_valid & out_ready, the source counter is cleared and idx is incremented. The handshake on idx 128 returns the FSM to ACQ.
- dump_req in DRAIN is ignored.
- Reset mid-operation: all counters and histograms are cleared, state → ACQ, out_valid=0 immediately (asynchronous).

## Timing
- Event-to-bin latency: the count updates at the clock edge that ends the detect cycle. It is visible to a dump at the next cycle.
- An event and dump_req in the same ACQ cycle: the event is counted and included in the frame.
- out_valid rises the cycle after dump_req is sampled. out_valid stays high for the whole of DRAIN.
- Handshake rules:
  - out_idx, out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - With out_ready held high, one word transfers per cycle, so a full drain takes 129 cycles.
- out_valid falls in the cycle after the last handshake. busy has identical timing to out_valid.
- Events arrive at most once every 3 cycles (a TDC guarantee), so no increment conflict exists. A clear and an increment never target the same bin in the same cycle, because increments are blocked in DRAIN.
- INTERVAL=63 is accepted as a normal bin. The TDC does not produce it.

## Structure
- Shared package tdc_pkg holds:
  - Channel-code constants: CH_NONE, CH_P2, CH_P1, CH_BOTH.
  - NUM_BINS=64 and WORDS=129.
  - The FSM state enum (ACQ, DRAIN).
- Sub-module tdc_event_decoder holds:
  - The data_arrived edge detect.
  - Classification into inc_fwd, inc_rev, inc_coinc and bin outputs, registered for one stage.
- The top level holds:
  - The 128×COUNT_W register array.
  - The coincidence and drop counters.
  - The FSM and the readout mux.

## Test plan
- Directed event scenarios:
  - Event (START=10, END=01, INTERVAL=5) plus one event (10,10,9), then dump with out_ready=1 → idx5=1, all other words 0, out_last on idx 128.
  - Event (01,10,17) then dump → idx81=1.
  - Event (00,11,0) → idx128=1, bin 0 of both histograms = 0.
- Saturation: COUNT_W=4, 20 events (10,01,3) → idx3=15.
- Backpressure and drop handling: during a drain, toggle out_ready 1/0 randomly → outputs stay stable while stalled and every index 0..128 appears exactly once. Inject one event mid-drain → dropped=1. A second dump returns all zeros.
- Reset and enable gating:
  - Assert rst_n=0 at drain word 40 → out_valid=0 at once. After release, a dump returns all zeros and dropped=0.
  - Events with acq_en=0 → no counts and dropped unchanged.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared constants and types for the TDC start/stop correlation histogrammer.
// Channel codes, histogram geometry and the readout FSM states.
package tdc_pkg;
    localparam logic [1:0] CH_NONE = 2'b00;
    localparam logic [1:0] CH_P2   = 2'b01;
    localparam logic [1:0] CH_P1   = 2'b10;
    localparam logic [1:0] CH_BOTH = 2'b11;

    localparam int NUM_BINS = 64;
    localparam int WORDS    = 2 * NUM_BINS + 1;
    // The final readout word carries the coincidence counter.
    localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

    typedef enum logic {
        ACQ   = 1'b0,
        DRAIN = 1'b1
    } state_e;
endpackage

// File: rtl/tdc_event_decoder.sv
// Detects the rising edge of the TDC strobe and classifies the event fields.
// The strobe history is the one registered stage, so outputs are valid in the detect cycle.
module tdc_event_decoder
    import tdc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_arrived,
    input  logic [1:0] start_sig,
    input  logic [1:0] end_sig,
    input  logic [5:0] interval,
    output logic       ev,
    output logic       inc_fwd,
    output logic       inc_rev,
    output logic       inc_coinc,
    output logic [5:0] bin
);
    logic data_arrived_q, data_arrived_d;

    always_comb begin
        data_arrived_d = data_arrived;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_arrived_q <= 1'b0;
        else        data_arrived_q <= data_arrived_d;
    end

    always_comb begin
        ev        = data_arrived & ~data_arrived_q;
        bin       = interval;
        inc_fwd   = ev && (start_sig == CH_P1)   && (end_sig == CH_P2);
        inc_rev   = ev && (start_sig == CH_P2)   && (end_sig == CH_P1);
        inc_coinc = ev && (start_sig == CH_NONE) && (end_sig == CH_BOTH);
    end
endmodule

// File: rtl/tdc_corr_histogram.sv
// Forward/reverse start-stop histograms plus coincidence counter, frozen and
// streamed out (clear-on-read) over a valid/ready port on dump request.
module tdc_corr_histogram
    import tdc_pkg::*;
#(
    parameter int COUNT_W = 16,
    parameter int DROP_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data_arrived,
    input  logic [1:0]         START_signal,
    input  logic [1:0]         END_signal,
    input  logic [5:0]         INTERVAL,
    input  logic               acq_en,
    input  logic               dump_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_idx,
    output logic [COUNT_W-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic [DROP_W-1:0]  dropped
);
    logic       ev, inc_fwd, inc_rev, inc_coinc;
    logic [5:0] bin;

    tdc_event_decoder u_dec (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_arrived (data_arrived),
        .start_sig    (START_signal),
        .end_sig      (END_signal),
        .interval     (INTERVAL),
        .ev           (ev),
        .inc_fwd      (inc_fwd),
        .inc_rev      (inc_rev),
        .inc_coinc    (inc_coinc),
        .bin          (bin)
    );

    state_e             state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic [COUNT_W-1:0] hist_q [2*NUM_BINS];
    logic [COUNT_W-1:0] hist_d [2*NUM_BINS];
    logic [COUNT_W-1:0] coinc_q, coinc_d;
    logic [DROP_W-1:0]  dropped_q, dropped_d;
    logic [6:0]         inc_addr;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hist_d    = hist_q;
        coinc_d   = coinc_q;
        dropped_d = dropped_q;
        // Reverse bins live in the upper half, matching readout word order.
        inc_addr  = {inc_rev, bin};
        case (state_q)
            ACQ: begin
                if (acq_en) begin
                    if ((inc_fwd || inc_rev) && (hist_q[inc_addr] != '1))
                        hist_d[inc_addr] = hist_q[inc_addr] + 1'b1;
                    if (inc_coinc && (coinc_q != '1))
                        coinc_d = coinc_q + 1'b1;
                end
                if (dump_req) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end
            end
            DRAIN: begin
                if (ev && (dropped_q != '1))
                    dropped_d = dropped_q + 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        coinc_d = '0;
                        state_d = ACQ;
                        idx_d   = '0;
                    end else begin
                        hist_d[idx_q[6:0]] = '0;
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = ACQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACQ;
            idx_q     <= '0;
            hist_q    <= '{default: '0};
            coinc_q   <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hist_q    <= hist_d;
            coinc_q   <= coinc_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        out_valid = (state_q == DRAIN);
        busy      = out_valid;
        out_idx   = idx_q;
        out_last  = out_valid && (idx_q == LAST_IDX);
        dropped   = dropped_q;
        out_data  = '0;
        if (out_valid)
            out_data = (idx_q == LAST_IDX) ? coinc_q : hist_q[idx_q[6:0]];
    end
endmodule
